// File: rtl/lotto_bet_scorer.sv
// Lottery bet scorer: streams PICKS bet numbers, counts hits against the winning set, accumulates a saturating payout.
// Optional duplicate-number rejection is enabled by defining LOTTO_BET_DUP_EN.
module lotto_bet_scorer #(
   parameter  int NUM_W    = 5,
   parameter  int PICKS    = 4,
   parameter  int SUM_W    = 10,
   parameter  int PAY_BASE = 5,
   localparam int IW       = $clog2(PICKS),
   localparam int HW       = $clog2(PICKS + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             win_we,
   input  logic [IW-1:0]    win_idx,
   input  logic [NUM_W-1:0] win_num,
   input  logic             num_valid,
   input  logic [NUM_W-1:0] num_in,
   output logic             num_ready,
   input  logic             rd_err,
   input  logic             clear,
   output logic [SUM_W-1:0] sum,
   output logic [HW-1:0]    hits,
   output logic             bet_done,
   output logic             bet_abort,
   output logic             sum_sat
);

   typedef enum logic [1:0] {IDLE, COLLECT, SCORE} state_t;

   // Elaboration-time geometric payout, clamped to the largest representable total.
   function automatic logic [SUM_W-1:0] pay_const(input int h);
      longint v;
      longint mx;
      mx = (longint'(1) << SUM_W) - 1;
      if (h == 0) return '0;
      v = 1;
      for (int k = 1; k < h; k++) begin
         v = v * PAY_BASE;
         if (v > mx) v = mx;
      end
      return v[SUM_W-1:0];
   endfunction

   // Returns {clamped, value}; the clamp flag is the carry out of the add.
   function automatic logic [SUM_W:0] sat_add(input logic [SUM_W-1:0] a,
                                              input logic [SUM_W-1:0] b);
      logic [SUM_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s[SUM_W]) return {1'b1, {SUM_W{1'b1}}};
      return s;
   endfunction

   state_t           state_q, state_d;
   logic [NUM_W-1:0] win_q [PICKS];
   logic [HW-1:0]    pos_q;
   logic [HW-1:0]    hit_q;
   logic [SUM_W-1:0] pay_tbl [PICKS+1];
   logic             accept;
   logic             num_hit;
   logic             last_num;
   logic [HW-1:0]    hit_inc;
   logic [SUM_W:0]   acc;
   logic             dup_q;

   for (genvar g = 0; g <= PICKS; g++) begin : g_pay
      assign pay_tbl[g] = pay_const(g);
   end

   always_comb begin
      num_hit = 1'b0;
      for (int i = 0; i < PICKS; i++)
         if (win_q[i] == num_in) num_hit = 1'b1;
   end

   assign accept   = num_valid & num_ready & ~rd_err;
   assign last_num = (pos_q == HW'(PICKS - 1));
   assign hit_inc  = {{(HW-1){1'b0}}, num_hit};
   assign acc      = sat_add(sum, pay_tbl[hit_q]);

`ifdef LOTTO_BET_DUP_EN
   logic [NUM_W-1:0] seen_q [PICKS];
   logic             dup_hit;

   always_comb begin
      dup_hit = 1'b0;
      for (int i = 0; i < PICKS; i++)
         if ((HW'(i) < pos_q) && (seen_q[i] == num_in)) dup_hit = 1'b1;
   end

   // The first number of a bet starts a fresh duplicate history.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dup_q <= 1'b0;
         for (int i = 0; i < PICKS; i++) seen_q[i] <= '0;
      end else if (accept) begin
         seen_q[pos_q[IW-1:0]] <= num_in;
         dup_q <= (state_q == IDLE) ? 1'b0 : (dup_q | dup_hit);
      end
   end
`else
   assign dup_q = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = COLLECT;
         COLLECT: begin
            if (rd_err)                  state_d = IDLE;
            else if (accept && last_num) state_d = SCORE;
         end
         SCORE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      num_ready = (state_q != SCORE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < PICKS; i++) win_q[i] <= '0;
         pos_q     <= '0;
         hit_q     <= '0;
         sum       <= '0;
         hits      <= '0;
         bet_done  <= 1'b0;
         bet_abort <= 1'b0;
         sum_sat   <= 1'b0;
      end else begin
         bet_done  <= 1'b0;
         bet_abort <= 1'b0;
         if (win_we && (state_q == IDLE) && (int'(win_idx) < PICKS))
            win_q[win_idx] <= win_num;

         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  pos_q <= HW'(1);
                  hit_q <= hit_inc;
               end
            end
            COLLECT: begin
               if (rd_err) begin
                  pos_q     <= '0;
                  hit_q     <= '0;
                  bet_abort <= 1'b1;
               end else if (accept) begin
                  pos_q <= pos_q + HW'(1);
                  hit_q <= hit_q + hit_inc;
               end
            end
            SCORE: begin
               pos_q <= '0;
               hit_q <= '0;
               if (dup_q) begin
                  hits      <= '0;
                  bet_abort <= 1'b1;
               end else begin
                  hits     <= hit_q;
                  bet_done <= 1'b1;
               end
            end
            default: ;
         endcase

         // Clear wins over a same-cycle accumulation.
         if (clear) begin
            sum     <= '0;
            sum_sat <= 1'b0;
         end else if ((state_q == SCORE) && !dup_q) begin
            sum <= acc[SUM_W-1:0];
            if (acc[SUM_W]) sum_sat <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_lotto_bet_scorer.sv
// Scoreboard bench for lotto_bet_scorer: stimulus pushes expected bet outcomes, a monitor checks each completion pulse.
module tb_lotto_bet_scorer;

   logic       clk = 1'b0;
   logic       reset;
   logic       win_we;
   logic [1:0] win_idx;
   logic [4:0] win_num;
   logic       num_valid;
   logic [4:0] num_in;
   logic       num_ready;
   logic       rd_err;
   logic       clear;
   logic [9:0] sum;
   logic [2:0] hits;
   logic       bet_done;
   logic       bet_abort;
   logic       sum_sat;

   typedef struct {
      bit done;
      int hits;
      int sum;
      bit sat;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   lotto_bet_scorer dut (
      .clk(clk), .reset(reset), .win_we(win_we), .win_idx(win_idx), .win_num(win_num),
      .num_valid(num_valid), .num_in(num_in), .num_ready(num_ready), .rd_err(rd_err),
      .clear(clear), .sum(sum), .hits(hits), .bet_done(bet_done), .bet_abort(bet_abort),
      .sum_sat(sum_sat)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor: every completion pulse must match the oldest expected outcome.
   always @(negedge clk) begin
      if (reset && (bet_done || bet_abort)) begin
         if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: got done=%0d abort=%0d, expected no pulse", bet_done, bet_abort);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("sb_kind", {bet_done, bet_abort}, e.done ? 2 : 1);
            chk("sb_hits", hits, e.hits);
            chk("sb_sum", sum, e.sum);
            chk("sb_sat", sum_sat, e.sat);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [4:0] n);
      int guard;
      num_valid = 1'b1;
      num_in    = n;
      guard     = 0;
      while (!num_ready && guard < 10) begin
         tick();
         guard++;
      end
      if (guard >= 10) chk("ready_timeout", num_ready, 1);
      tick();
      num_valid = 1'b0;
   endtask

   task automatic setw(input logic [1:0] idx, input logic [4:0] val);
      win_we  = 1'b1;
      win_idx = idx;
      win_num = val;
      tick();
      win_we  = 1'b0;
   endtask

   task automatic bet(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                      input logic [4:0] d, input bit ed, input int eh, input int es, input bit esat);
      q.push_back('{ed, eh, es, esat});
      send(a); send(b); send(c); send(d);
      chk("ready_in_score", num_ready, 0);
      tick();
      chk("ready_after_score", num_ready, 1);
      chk("pulse_after_score", ed ? int'(bet_done) : int'(bet_abort), 1);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clear_sum", sum, 0);
      chk("clear_sat", sum_sat, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      reset = 1'b0; win_we = 0; win_idx = 0; win_num = 0;
      num_valid = 0; num_in = 0; rd_err = 0; clear = 0;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      chk("rst_sum", sum, 0);
      chk("rst_hits", hits, 0);
      chk("rst_done", bet_done, 0);
      chk("rst_abort", bet_abort, 0);
      chk("rst_sat", sum_sat, 0);
      chk("rst_ready", num_ready, 1);

      setw(0, 3); setw(1, 7); setw(2, 12); setw(3, 20);
      bet(3, 7, 12, 20, 1, 4, 125, 0);

      do_clear();
      bet(3, 1, 2, 4, 1, 1, 1, 0);
      bet(3, 7, 1, 2, 1, 2, 6, 0);

      // Abort after two numbers.
      send(3); send(7);
      q.push_back('{0, 2, 6, 0});
      rd_err = 1'b1;
      tick();
      rd_err = 1'b0;
      chk("abort_pulse", bet_abort, 1);
      tick();
      chk("abort_one_cycle", bet_abort, 0);
      bet(7, 12, 20, 9, 1, 3, 31, 0);

      for (int k = 1; k <= 9; k++) begin
         int raw;
         raw = 31 + 125 * k;
         bet(3, 7, 12, 20, 1, 4, (raw > 1023) ? 1023 : raw, raw > 1023);
      end
      do_clear();

      // Winning-number write during COLLECT must not change the set.
      q.push_back('{1, 0, 0, 0});
      send(1);
      win_we = 1'b1; win_idx = 1; win_num = 9;
      send(2);
      win_we = 1'b0;
      send(9); send(4);
      tick();
      chk("we_collect_done", bet_done, 1);
      bet(3, 1, 2, 4, 1, 1, 1, 0);

      // Asynchronous reset mid-bet.
      send(3); send(7);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_sum", sum, 0);
      chk("mid_rst_hits", hits, 0);
      chk("mid_rst_ready", num_ready, 1);
      chk("mid_rst_done", bet_done, 0);
      chk("mid_rst_abort", bet_abort, 0);
      chk("mid_rst_sat", sum_sat, 0);
      repeat (2) tick();
      reset = 1'b1;
      tick();
      chk("post_rst_sum", sum, 0);

      setw(0, 3); setw(1, 7); setw(2, 12); setw(3, 20);
`ifdef LOTTO_BET_DUP_EN
      bet(3, 3, 7, 12, 0, 0, 0, 0);
      bet(3, 7, 12, 20, 1, 4, 125, 0);
`else
      bet(3, 3, 7, 12, 1, 4, 125, 0);
      bet(3, 7, 12, 20, 1, 4, 250, 0);
`endif

      repeat (3) tick();
      chk("sb_drain", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lotto_bet_scorer.md
# lotto_bet_scorer

Parametrised, clocked successor to the per-number bet checker. Holds a set of PICKS winning numbers, accepts one bet number per cycle over a valid/ready handshake, counts hits per bet, and adds a geometric payout into a saturating running total. Sits between the ticket reader, which streams bet numbers and the read-error flag, and the cash display/accounting logic.

## Interface
- NUM_W, 5: width of one lottery number.
- PICKS, 4: numbers per bet and winning numbers held; PICKS ≥ 2.
- SUM_W, 10: width of the cash total.
- PAY_BASE, 5: payout multiplier. pay(0)=0, pay(h)=PAY_BASE^(h-1) for h ≥ 1, each entry saturated to 2^SUM_W-1.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- win_we  in  1  write strobe for one winning-number slot.
- win_idx  in  clog2(PICKS)  winning slot index.
- win_num  in  NUM_W  winning number value.
- num_valid  in  1  bet number present.
- num_in  in  NUM_W  bet number.
- num_ready  out  1  scorer can accept a number.
- rd_err  in  1  reader error; aborts the bet in progress.
- clear  in  1  synchronous clear of sum and sum_sat.
- sum  out  SUM_W  accumulated winnings.
- hits  out  clog2(PICKS+1)  hit count of the last completed bet.
- bet_done  out  1  one-cycle pulse when a bet is scored.
- bet_abort  out  1  one-cycle pulse when a bet is discarded.
- sum_sat  out  1  sticky flag: the total has saturated.

## Operation
- States: IDLE, COLLECT, SCORE.
- IDLE: win_we writes W[win_idx] ← win_num. An out-of-range win_idx is ignored. The first accepted number moves the FSM to COLLECT with pos=1.
- COLLECT: win_we is ignored, so the winning set stays stable during a bet. Each accepted number increments pos. When the PICKS-th number is accepted, the FSM goes to SCORE.
- Hit test: a number is a hit if it equals any W[i]. The running hit count starts at 0 with the first number of each bet.
- SCORE: sum ← min(sum + pay(hit_count), 2^SUM_W-1). If the clamp applies, sum_sat is set. hits ← hit_count, bet_done=1, then the FSM returns to IDLE.
- num_ready = 1 in IDLE and COLLECT, 0 in SCORE.
- A number is accepted when num_valid & num_ready & !rd_err.
- rd_err high in COLLECT: the partial bet is discarded, pos and hit count go to 0, bet_abort pulses, and the FSM goes to IDLE. sum and hits are unchanged. rd_err in IDLE or SCORE has no effect beyond blocking acceptance; SCORE still completes.
- clear: zeroes sum and sum_sat and has priority over an accumulation in the same cycle. The bet in progress is unaffected.
- Reset values: sum=0, hits=0, bet_done=0, bet_abort=0, sum_sat=0, num_ready=1, all W[i]=0, FSM=IDLE, pos=0. Reset is asynchronous mid-bet and discards the bet silently, with no bet_abort.

## Timing
- Throughput: one number per cycle. A PICKS-number bet takes PICKS accept cycles plus 1 SCORE cycle.
- sum, hits and bet_done all update on the edge that leaves SCORE, one cycle after the last number is accepted.
- bet_abort is registered and asserts the cycle after the rd_err sample.
- A winning-number write is visible to the hit test for a number accepted in the following cycle.
- Pay table is fixed at elaboration; no runtime multiply.

## Configuration
- LOTTO_BET_DUP_EN defined: each accepted number is compared against the earlier numbers of the same bet.
  - A repeat sets an internal dup flag.
  - In SCORE, a flagged bet adds 0 to sum, sets hits=0, and pulses bet_abort instead of bet_done.
  - The dup flag clears on the first number of the next bet.
- Macro undefined: no duplicate check. Repeated numbers each count as hits.

## Test plan
- Reset, W={3,7,12,20}, bet 3,7,12,20 back-to-back → bet_done one cycle after the 4th number, hits=4, sum=125.
- Same W, bets {3,1,2,4} then {3,7,1,2} → sum 1 then 6, hits 1 then 2, num_ready=0 exactly in each SCORE cycle.
- rd_err asserted after 2 numbers of a bet → bet_abort pulse, sum unchanged. The next full bet {7,12,20,9} → sum += 25.
- Repeated 4-hit bets until the total exceeds 1023 → sum clamps at 1023, sum_sat=1. Then clear → sum=0, sum_sat=0.
- win_we during COLLECT is ignored. Reset asserted mid-bet → all outputs at reset values immediately, with no bet_done or bet_abort.
- With LOTTO_BET_DUP_EN defined, bet {3,3,7,12} → bet_abort, sum unchanged, hits=0. With the macro undefined, the same bet gives hits=4, sum += 125.
